ctrl_unit_pipe: RTL and testbench
=================================

// Module: ctrl_unit_pipe
// PURPOSE
// - Registered, condition-aware decode controller for the ID stage; drives the ID/EX control fields.
// - Decodes mode/opcode/s into exec command and control bits, and squashes the instruction if its ARM condition fails against NZCV.
// - Freezes upstream for MEM_LAT bubble cycles after each issued LDR/STR, and applies hazard-stall and branch-flush bubbles.
// PARAMETERS
// - EXEC_W   4  width of exec_cmd; must be >= 4, upper bits zero
// - MEM_LAT  2  bubble cycles inserted after an issued memory op; 0..15, 0 means no freeze
// - COND_EN  1  1 evaluates cond; 0 treats every instruction as AL
// PORTS
// - clk         in   1       rising-edge clock (single clock domain)
// - rst         in   1       synchronous, active-high reset
// - valid_in    in   1       ID holds a real instruction; 0 means NOP
// - cond        in   4       ARM condition field
// - mode        in   2       00 data-proc, 01 load/store, 10 branch, 11 reserved
// - opcode      in   4       data-proc opcode
// - s           in   1       data-proc: update flags; load/store: 1=LDR, 0=STR
// - status      in   4       NZCV {N,Z,C,V} from the status register
// - hazard      in   1       hazard unit requests a stall
// - flush       in   1       branch taken in EX; kill the ID instruction
// - valid_out   out  1       ID/EX entry is a live instruction
// - b_jump      out  1       branch
// - wb_en       out  1       register write-back
// - mem_rd      out  1       memory read
// - mem_wr      out  1       memory write
// - exec_cmd    out  EXEC_W  ALU command
// - s_out       out  1       update status flags
// - stall_out   out  1       IF/ID must hold (combinational)
// BEHAVIOUR
// - Reset: all registered outputs 0; FSM IDLE; counter 0. stall_out = 0.
// - Latency: 1 cycle. Decode is combinational; results are registered into the outputs on the next clk edge.
// - Decode, mode 00:
//   - MOV=1101 -> cmd 1; ADD=0100 -> 2; ADC=0101 -> 3; SUB=0010 -> 4; SBC=0110 -> 5.
//   - AND=0000 -> 6; ORR=1100 -> 7; EOR=0001 -> 8; MVN=1111 -> 9. All of these set wb_en=1, s_out=s.
//   - CMP=1010 -> cmd 4, TST=1000 -> cmd 6; both wb_en=0, s_out=1.
//   - Any other opcode -> all outputs 0, valid_out=1.
// - Decode, mode 01:
//   - cmd 2 (address add); s_out=0.
//   - LDR: mem_rd=1, wb_en=1. STR: mem_wr=1.
// - Decode, mode 10: b_jump=1; all other fields 0.
// - Decode, mode 11: treated as NOP.
// - Condition pass, cond -> pass:
//   - EQ 0000 Z; NE 0001 !Z; CS 0010 C; CC 0011 !C; MI 0100 N; PL 0101 !N; VS 0110 V; VC 0111 !V.
//   - HI 1000 C&!Z; LS 1001 !C|Z; GE 1010 N==V; LT 1011 N!=V; GT 1100 !Z&(N==V); LE 1101 Z|(N!=V).
//   - AL 1110 always; 1111 never.
// - issue = valid_in & pass & !stall_out. The register loads the decoded fields with valid_out=1 only when issue=1; otherwise it loads a bubble (all 0).
// - Priority per edge: rst > flush > (hazard | FSM WAIT) > issue.
// - FSM IDLE:
//   - An issued mode-01 op with MEM_LAT>0 -> WAIT, cnt=MEM_LAT.
//   - Only the issuing cycle counts; a failed-condition memory op does not enter WAIT.
// - FSM WAIT:
//   - stall_out=1; outputs take a bubble each cycle; cnt decrements.
//   - cnt==1 -> IDLE on the next edge, so the freeze lasts exactly MEM_LAT cycles.
// - stall_out = hazard | (state==WAIT).
// - flush: the next edge loads a bubble and kills ID. If the FSM is in WAIT it keeps counting, because the memory op has already issued.
// - hazard during WAIT: no extra effect; the counter keeps running.
// - rst mid-WAIT: IDLE, cnt=0, bubble.
// - Flags are never read in the same cycle they are written; forwarding of NZCV is out of scope.
// STRUCTURE
// - Shared package ctrl_pkg:
//   - mode localparams MODE_DP/MODE_MEM/MODE_BR;
//   - opcode constants OP_MOV..OP_TST;
//   - EXEC_* command codes 1..9;
//   - COND_* codes.
// - One sub-module, cond_check (cond, status -> pass), purely combinational.
// - Decode is an always_comb case block; one registered ID/EX control struct; 2-state FSM plus 4-bit counter.
// TESTING
// - Reset, then valid_in=1, mode=00, opcode=0100, s=1, cond=1110: one cycle later exec_cmd=2, wb_en=1, s_out=1, valid_out=1.
// - cond=0000 (EQ): with status=0000 -> bubble (valid_out=0); with status=0100 -> MOV issues, exec_cmd=1.
// - LDR (mode 01, s=1), MEM_LAT=2: next cycle mem_rd=1, wb_en=1, exec_cmd=2. stall_out=1 for exactly 2 cycles with bubbles, then the next instruction issues.
// - flush=1 while ID holds ADD: next cycle valid_out=0. flush during WAIT: stall_out still ends on schedule.
// - hazard=1 for 3 cycles: 3 bubbles, stall_out=1. Instruction issues on the cycle after hazard drops.
// - rst asserted in WAIT with cnt=1: next cycle stall_out=0 and all outputs 0. CMP (1010) -> exec_cmd=4, wb_en=0, s_out=1.

Source files
------------

// File: rtl/ctrl_pkg.sv
// Shared decode constants and the ID/EX control record for ctrl_unit_pipe.
package ctrl_pkg;

  localparam logic [1:0] MODE_DP  = 2'b00;
  localparam logic [1:0] MODE_MEM = 2'b01;
  localparam logic [1:0] MODE_BR  = 2'b10;

  localparam logic [3:0] OP_MOV = 4'b1101;
  localparam logic [3:0] OP_ADD = 4'b0100;
  localparam logic [3:0] OP_ADC = 4'b0101;
  localparam logic [3:0] OP_SUB = 4'b0010;
  localparam logic [3:0] OP_SBC = 4'b0110;
  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_ORR = 4'b1100;
  localparam logic [3:0] OP_EOR = 4'b0001;
  localparam logic [3:0] OP_MVN = 4'b1111;
  localparam logic [3:0] OP_CMP = 4'b1010;
  localparam logic [3:0] OP_TST = 4'b1000;

  localparam logic [3:0] EXEC_MOV = 4'd1;
  localparam logic [3:0] EXEC_ADD = 4'd2;
  localparam logic [3:0] EXEC_ADC = 4'd3;
  localparam logic [3:0] EXEC_SUB = 4'd4;
  localparam logic [3:0] EXEC_SBC = 4'd5;
  localparam logic [3:0] EXEC_AND = 4'd6;
  localparam logic [3:0] EXEC_ORR = 4'd7;
  localparam logic [3:0] EXEC_EOR = 4'd8;
  localparam logic [3:0] EXEC_MVN = 4'd9;

  localparam logic [3:0] COND_EQ = 4'b0000;
  localparam logic [3:0] COND_NE = 4'b0001;
  localparam logic [3:0] COND_CS = 4'b0010;
  localparam logic [3:0] COND_CC = 4'b0011;
  localparam logic [3:0] COND_MI = 4'b0100;
  localparam logic [3:0] COND_PL = 4'b0101;
  localparam logic [3:0] COND_VS = 4'b0110;
  localparam logic [3:0] COND_VC = 4'b0111;
  localparam logic [3:0] COND_HI = 4'b1000;
  localparam logic [3:0] COND_LS = 4'b1001;
  localparam logic [3:0] COND_GE = 4'b1010;
  localparam logic [3:0] COND_LT = 4'b1011;
  localparam logic [3:0] COND_GT = 4'b1100;
  localparam logic [3:0] COND_LE = 4'b1101;
  localparam logic [3:0] COND_AL = 4'b1110;

  typedef struct packed {
    logic       valid;
    logic       b_jump;
    logic       wb_en;
    logic       mem_rd;
    logic       mem_wr;
    logic [3:0] cmd;
    logic       s;
  } idex_t;

  localparam idex_t BUBBLE = '0;

  typedef enum logic {ST_IDLE, ST_WAIT} state_t;

endpackage

// File: rtl/cond_check.sv
// Combinational ARM condition evaluation against NZCV {N,Z,C,V}.
module cond_check
  import ctrl_pkg::*;
(
  input  logic [3:0] cond,
  input  logic [3:0] status,
  output logic       pass
);

  logic n, z, c, v;
  assign {n, z, c, v} = status;

  always_comb begin
    pass = 1'b0;
    case (cond)
      COND_EQ: pass = z;
      COND_NE: pass = !z;
      COND_CS: pass = c;
      COND_CC: pass = !c;
      COND_MI: pass = n;
      COND_PL: pass = !n;
      COND_VS: pass = v;
      COND_VC: pass = !v;
      COND_HI: pass = c && !z;
      COND_LS: pass = !c || z;
      COND_GE: pass = (n == v);
      COND_LT: pass = (n != v);
      COND_GT: pass = !z && (n == v);
      COND_LE: pass = z || (n != v);
      COND_AL: pass = 1'b1;
      default: pass = 1'b0;
    endcase
  end

endmodule

// File: rtl/ctrl_unit_pipe.sv
// ID-stage decode controller: registers ID/EX control one cycle after decode,
// squashes failed conditions and freezes upstream for MEM_LAT cycles after a memory op.
module ctrl_unit_pipe
  import ctrl_pkg::*;
#(
  parameter int unsigned EXEC_W  = 4,
  parameter int unsigned MEM_LAT = 2,
  parameter int unsigned COND_EN = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              valid_in,
  input  logic [3:0]        cond,
  input  logic [1:0]        mode,
  input  logic [3:0]        opcode,
  input  logic              s,
  input  logic [3:0]        status,
  input  logic              hazard,
  input  logic              flush,
  output logic              valid_out,
  output logic              b_jump,
  output logic              wb_en,
  output logic              mem_rd,
  output logic              mem_wr,
  output logic [EXEC_W-1:0] exec_cmd,
  output logic              s_out,
  output logic              stall_out
);

  localparam logic [3:0] LAT4 = 4'(MEM_LAT);

  state_t     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  idex_t      q, q_d, dec;
  logic       cond_pass, pass, issue;

  cond_check u_cond (
    .cond   (cond),
    .status (status),
    .pass   (cond_pass)
  );

  assign pass      = (COND_EN != 0) ? cond_pass : 1'b1;
  assign stall_out = hazard || (state_q == ST_WAIT);
  assign issue     = valid_in && pass && !stall_out;

  always_comb begin
    dec = BUBBLE;
    case (mode)
      MODE_DP: begin
        dec.valid = 1'b1;
        case (opcode)
          OP_MOV: begin dec.cmd = EXEC_MOV; dec.wb_en = 1'b1; dec.s = s; end
          OP_ADD: begin dec.cmd = EXEC_ADD; dec.wb_en = 1'b1; dec.s = s; end
          OP_ADC: begin dec.cmd = EXEC_ADC; dec.wb_en = 1'b1; dec.s = s; end
          OP_SUB: begin dec.cmd = EXEC_SUB; dec.wb_en = 1'b1; dec.s = s; end
          OP_SBC: begin dec.cmd = EXEC_SBC; dec.wb_en = 1'b1; dec.s = s; end
          OP_AND: begin dec.cmd = EXEC_AND; dec.wb_en = 1'b1; dec.s = s; end
          OP_ORR: begin dec.cmd = EXEC_ORR; dec.wb_en = 1'b1; dec.s = s; end
          OP_EOR: begin dec.cmd = EXEC_EOR; dec.wb_en = 1'b1; dec.s = s; end
          OP_MVN: begin dec.cmd = EXEC_MVN; dec.wb_en = 1'b1; dec.s = s; end
          OP_CMP: begin dec.cmd = EXEC_SUB; dec.s = 1'b1; end
          OP_TST: begin dec.cmd = EXEC_AND; dec.s = 1'b1; end
          default: ;
        endcase
      end
      MODE_MEM: begin
        dec.valid  = 1'b1;
        dec.cmd    = EXEC_ADD;
        dec.mem_rd = s;
        dec.wb_en  = s;
        dec.mem_wr = !s;
      end
      MODE_BR: begin
        dec.valid  = 1'b1;
        dec.b_jump = 1'b1;
      end
      default: ;
    endcase
  end

  // A flushed instruction never issued, so it cannot start a freeze; a freeze
  // already running keeps counting through flush and hazard.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    q_d     = BUBBLE;
    if (!flush && issue) q_d = dec;
    case (state_q)
      ST_IDLE: begin
        if (!flush && issue && (mode == MODE_MEM) && (MEM_LAT > 0)) begin
          state_d = ST_WAIT;
          cnt_d   = LAT4;
        end
      end
      ST_WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= 4'd0;
      q       <= BUBBLE;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      q       <= q_d;
    end
  end

  assign valid_out = q.valid;
  assign b_jump    = q.b_jump;
  assign wb_en     = q.wb_en;
  assign mem_rd    = q.mem_rd;
  assign mem_wr    = q.mem_wr;
  assign exec_cmd  = EXEC_W'(q.cmd);
  assign s_out     = q.s;

endmodule

// File: tb/tb_ctrl_unit_pipe.sv
// Self-checking bench for ctrl_unit_pipe: decode table, corner sequences, random run vs model.
module tb_ctrl_unit_pipe;

  localparam int MEM_LAT = 2;

  logic       clk = 1'b0;
  logic       rst, valid_in, s, hazard, flush;
  logic [3:0] cond, opcode, status;
  logic [1:0] mode;
  logic       valid_out, b_jump, wb_en, mem_rd, mem_wr, s_out, stall_out;
  logic [3:0] exec_cmd;
  logic [9:0] obs;

  int n_cmp = 0;
  int n_bad = 0;
  int freeze = 0;

  always #5 clk = ~clk;

  ctrl_unit_pipe #(.EXEC_W(4), .MEM_LAT(MEM_LAT), .COND_EN(1)) dut (
    .clk(clk), .rst(rst), .valid_in(valid_in), .cond(cond), .mode(mode),
    .opcode(opcode), .s(s), .status(status), .hazard(hazard), .flush(flush),
    .valid_out(valid_out), .b_jump(b_jump), .wb_en(wb_en), .mem_rd(mem_rd),
    .mem_wr(mem_wr), .exec_cmd(exec_cmd), .s_out(s_out), .stall_out(stall_out)
  );

  assign obs = {valid_out, b_jump, wb_en, mem_rd, mem_wr, exec_cmd, s_out};

  typedef struct {
    logic       v;
    logic [3:0] cond;
    logic [1:0] mode;
    logic [3:0] op;
    logic       s;
    logic [3:0] st;
    logic [9:0] exp;
  } vec_t;

  vec_t tbl[16];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ARM conditions come in pairs: even code tests a predicate, odd code its inverse.
  function automatic logic cond_ok(input logic [3:0] c, input logic [3:0] nzcv);
    logic n, z, cf, v, base;
    {n, z, cf, v} = nzcv;
    case (c[3:1])
      3'd0: base = z;
      3'd1: base = cf;
      3'd2: base = n;
      3'd3: base = v;
      3'd4: base = cf & ~z;
      3'd5: base = (n == v);
      3'd6: base = ~z & (n == v);
      default: base = 1'b1;
    endcase
    return c[0] ? ~base : base;
  endfunction

  function automatic logic [9:0] model_dec(input logic v, input logic [3:0] c, input logic [1:0] m,
                                           input logic [3:0] op, input logic sb, input logic [3:0] st);
    logic [3:0] cmd;
    logic wb, sf;
    if (!v || !cond_ok(c, st)) return 10'd0;
    if (m == 2'd1) return {1'b1, 1'b0, sb, sb, ~sb, 4'd2, 1'b0};
    if (m == 2'd2) return {1'b1, 1'b1, 8'd0};
    if (m == 2'd3) return 10'd0;
    wb = 1'b1;
    sf = sb;
    case (op)
      4'hD: cmd = 4'd1;
      4'h4: cmd = 4'd2;
      4'h5: cmd = 4'd3;
      4'h2: cmd = 4'd4;
      4'h6: cmd = 4'd5;
      4'h0: cmd = 4'd6;
      4'hC: cmd = 4'd7;
      4'h1: cmd = 4'd8;
      4'hF: cmd = 4'd9;
      4'hA: begin cmd = 4'd4; wb = 1'b0; sf = 1'b1; end
      4'h8: begin cmd = 4'd6; wb = 1'b0; sf = 1'b1; end
      default: begin cmd = 4'd0; wb = 1'b0; sf = 1'b0; end
    endcase
    return {1'b1, 1'b0, wb, 1'b0, 1'b0, cmd, sf};
  endfunction

  // One clock with the current inputs: check stall mid-cycle, outputs after the edge.
  task automatic step(input string tag);
    logic [9:0] nxt;
    logic       stall_exp, issued;
    int         nfreeze;
    #2;
    stall_exp = hazard || (freeze > 0);
    chk({tag, ".stall"}, {31'd0, stall_out}, {31'd0, stall_exp});
    nxt = model_dec(valid_in, cond, mode, opcode, s, status);
    issued = !stall_exp && (nxt[9] == 1'b1) && !flush;
    if (rst || flush || stall_exp) nxt = 10'd0;
    if (rst) nfreeze = 0;
    else if (freeze > 0) nfreeze = freeze - 1;
    else if (issued && mode == 2'd1) nfreeze = MEM_LAT;
    else nfreeze = 0;
    @(posedge clk);
    #1;
    chk({tag, ".outs"}, {22'd0, obs}, {22'd0, nxt});
    freeze = nfreeze;
  endtask

  task automatic drive(input logic v, input logic [3:0] c, input logic [1:0] m,
                       input logic [3:0] op, input logic sb, input logic [3:0] st);
    valid_in = v; cond = c; mode = m; opcode = op; s = sb; status = st;
  endtask

  initial begin
    rst = 1'b1; hazard = 1'b0; flush = 1'b0;
    drive(1'b0, 4'hE, 2'd0, 4'h0, 1'b0, 4'h0);
    repeat (2) @(posedge clk);
    #1;
    chk("reset.outs", {22'd0, obs}, 32'd0);
    chk("reset.stall", {31'd0, stall_out}, 32'd0);
    rst = 1'b0;

    tbl[0]  = '{1'b1, 4'hE, 2'd0, 4'h4, 1'b1, 4'h0, 10'b1_0_1_0_0_0010_1};
    tbl[1]  = '{1'b1, 4'h0, 2'd0, 4'hD, 1'b0, 4'h0, 10'b0};
    tbl[2]  = '{1'b1, 4'h0, 2'd0, 4'hD, 1'b0, 4'h4, 10'b1_0_1_0_0_0001_0};
    tbl[3]  = '{1'b1, 4'hE, 2'd0, 4'hA, 1'b0, 4'h0, 10'b1_0_0_0_0_0100_1};
    tbl[4]  = '{1'b1, 4'hE, 2'd0, 4'h8, 1'b0, 4'h0, 10'b1_0_0_0_0_0110_1};
    tbl[5]  = '{1'b1, 4'hE, 2'd0, 4'hF, 1'b1, 4'h0, 10'b1_0_1_0_0_1001_1};
    tbl[6]  = '{1'b1, 4'hE, 2'd0, 4'h3, 1'b1, 4'h0, 10'b1_0_0_0_0_0000_0};
    tbl[7]  = '{1'b1, 4'hE, 2'd1, 4'h0, 1'b1, 4'h0, 10'b1_0_1_1_0_0010_0};
    tbl[8]  = '{1'b1, 4'hE, 2'd1, 4'h0, 1'b0, 4'h0, 10'b1_0_0_0_1_0010_0};
    tbl[9]  = '{1'b1, 4'hE, 2'd2, 4'h4, 1'b1, 4'h0, 10'b1_1_0_0_0_0000_0};
    tbl[10] = '{1'b1, 4'hE, 2'd3, 4'h4, 1'b1, 4'h0, 10'b0};
    tbl[11] = '{1'b0, 4'hE, 2'd0, 4'h4, 1'b1, 4'h0, 10'b0};
    tbl[12] = '{1'b1, 4'hF, 2'd0, 4'h4, 1'b1, 4'hF, 10'b0};
    tbl[13] = '{1'b1, 4'hC, 2'd0, 4'h2, 1'b0, 4'h9, 10'b1_0_1_0_0_0100_0};
    tbl[14] = '{1'b1, 4'hB, 2'd0, 4'hC, 1'b0, 4'h8, 10'b1_0_1_0_0_0111_0};
    tbl[15] = '{1'b1, 4'h8, 2'd0, 4'h1, 1'b1, 4'h2, 10'b1_0_1_0_0_1000_1};

    for (int i = 0; i < 16; i++) begin
      drive(tbl[i].v, tbl[i].cond, tbl[i].mode, tbl[i].op, tbl[i].s, tbl[i].st);
      step($sformatf("vec%0d", i));
      chk($sformatf("vec%0d.table", i), {22'd0, obs}, {22'd0, tbl[i].exp});
      valid_in = 1'b0;
      repeat (MEM_LAT) step("drain");
    end

    // LDR freeze, with ADD waiting in ID behind it
    drive(1'b1, 4'hE, 2'd1, 4'h0, 1'b1, 4'h0);
    step("ldr");
    drive(1'b1, 4'hE, 2'd0, 4'h4, 1'b1, 4'h0);
    chk("ldr.stall1", {31'd0, stall_out}, 32'd1);
    step("ldr.w1");
    chk("ldr.stall2", {31'd0, stall_out}, 32'd1);
    step("ldr.w2");
    chk("ldr.release", {31'd0, stall_out}, 32'd0);
    step("ldr.add");
    chk("ldr.add_cmd", {28'd0, exec_cmd}, 32'd2);

    // flush kills ADD in ID
    flush = 1'b1;
    step("flush");
    chk("flush.valid", {31'd0, valid_out}, 32'd0);
    flush = 1'b0;

    // flush during WAIT does not shorten the freeze
    drive(1'b1, 4'hE, 2'd1, 4'h0, 1'b0, 4'h0);
    step("str");
    flush = 1'b1;
    step("str.flush");
    flush = 1'b0;
    step("str.w2");
    chk("str.release", {31'd0, stall_out}, 32'd0);

    // three hazard cycles, ADD issues when hazard drops
    drive(1'b1, 4'hE, 2'd0, 4'h4, 1'b1, 4'h0);
    hazard = 1'b1;
    repeat (3) step("hz");
    hazard = 1'b0;
    step("hz.issue");
    chk("hz.valid", {31'd0, valid_out}, 32'd1);

    // reset in WAIT with one bubble remaining
    drive(1'b1, 4'hE, 2'd1, 4'h0, 1'b1, 4'h0);
    step("rw.ldr");
    valid_in = 1'b0;
    step("rw.w1");
    rst = 1'b1;
    step("rw.rst");
    rst = 1'b0;
    chk("rw.stall", {31'd0, stall_out}, 32'd0);
    chk("rw.outs", {22'd0, obs}, 32'd0);

    for (int k = 0; k < 400; k++) begin
      rst    = ($urandom_range(0, 49) == 0);
      hazard = ($urandom_range(0, 7) == 0);
      flush  = ($urandom_range(0, 9) == 0);
      drive($urandom_range(0, 3) != 0,
            ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'hE,
            2'($urandom), 4'($urandom), 1'($urandom), 4'($urandom));
      step($sformatf("rnd%0d", k));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
